// File: rtl/mem_port_arb_if.sv
// Handshake bundle between the memory port arbiter, its two requesters (IF, LS) and the memory bus.
// MEM_ARB_ERR_EN adds the memory error input and the per-requester error outputs.
interface mem_port_arb_if #(
  parameter int XLEN = 32
);
  logic            flush_i;

  logic            if_req_i;
  logic [XLEN-1:0] if_adr_i;
  logic            if_gnt_o;
  logic            if_rvalid_o;
  logic [XLEN-1:0] if_rdata_o;

  logic            ls_req_i;
  logic [XLEN-1:0] ls_adr_i;
  logic            ls_we_i;
  logic [XLEN-1:0] ls_wdata_i;
  logic [2:0]      ls_size_i;
  logic            ls_gnt_o;
  logic            ls_rvalid_o;
  logic [XLEN-1:0] ls_rdata_o;

  logic            mem_req_o;
  logic [XLEN-1:0] mem_adr_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic [2:0]      mem_size_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;

`ifdef MEM_ARB_ERR_EN
  logic            mem_err_i;
  logic            if_err_o;
  logic            ls_err_o;
`endif

  // Arbiter side
  modport master (
    input  flush_i,
    input  if_req_i, if_adr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_req_i, ls_adr_i, ls_we_i, ls_wdata_i, ls_size_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output mem_req_o, mem_adr_o, mem_we_o, mem_wdata_o, mem_size_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
`ifdef MEM_ARB_ERR_EN
    , input mem_err_i, output if_err_o, ls_err_o
`endif
  );

  // Requester / memory side
  modport slave (
    output flush_i,
    output if_req_i, if_adr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_req_i, ls_adr_i, ls_we_i, ls_wdata_i, ls_size_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  mem_req_o, mem_adr_o, mem_we_o, mem_wdata_o, mem_size_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
`ifdef MEM_ARB_ERR_EN
    , output mem_err_i, input if_err_o, ls_err_o
`endif
  );
endinterface

// File: rtl/mem_port_arb.sv
// Shared memory port arbiter: one outstanding transaction, LS priority with IF anti-starvation, IF flush.
// Optional MEM_ARB_ERR_EN routes mem_err_i to the owning requester as if_err_o / ls_err_o.
module mem_port_arb #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           reset_n,
  mem_port_arb_if.master bus
);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [2:0] SIZE_WORD  = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  typedef enum logic       {OWN_LS, OWN_IF}         owner_t;

  typedef struct packed {
    logic [XLEN-1:0] adr;
    logic            we;
    logic [XLEN-1:0] wdata;
    logic [2:0]      size;
  } mem_cmd_t;

  state_t     state;
  owner_t     owner;
  logic [3:0] starve_cnt;
  logic       cancelled;
  logic       mem_req_q;
  mem_cmd_t   cmd_q;

  logic     if_elig, if_win, ls_win, own_if, if_flush;
  mem_cmd_t if_cmd, ls_cmd;

  // A flushed fetch is not eligible; otherwise LS wins unless IF has been passed over STARVE_MAX times.
  assign if_elig = bus.if_req_i & ~bus.flush_i;
  assign if_win  = if_elig & (~bus.ls_req_i | (starve_cnt == STARVE_LIM));
  assign ls_win  = bus.ls_req_i & ~if_win;

  assign own_if   = (owner == OWN_IF);
  assign if_flush = own_if & bus.flush_i;

  assign if_cmd = '{adr: bus.if_adr_i, we: 1'b0, wdata: '0, size: SIZE_WORD};
  assign ls_cmd = '{adr: bus.ls_adr_i, we: bus.ls_we_i, wdata: bus.ls_wdata_i, size: bus.ls_size_i};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      owner      <= OWN_LS;
      starve_cnt <= '0;
      cancelled  <= 1'b0;
      mem_req_q  <= 1'b0;
      cmd_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (if_win || ls_win) begin
            state     <= S_ISSUE;
            mem_req_q <= 1'b1;
            cancelled <= 1'b0;
            owner     <= if_win ? OWN_IF : OWN_LS;
            cmd_q     <= if_win ? if_cmd : ls_cmd;
            if (if_win)
              starve_cnt <= '0;
            else if (bus.if_req_i && starve_cnt != STARVE_LIM)
              starve_cnt <= starve_cnt + 4'd1;
          end
        end
        S_ISSUE: begin
          // Grant beats a same-cycle flush; the fetch is then only marked cancelled.
          if (bus.mem_gnt_i) begin
            state     <= S_WAIT;
            mem_req_q <= 1'b0;
            cancelled <= if_flush;
          end else if (if_flush) begin
            state     <= S_IDLE;
            mem_req_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (if_flush)
            cancelled <= 1'b1;
          if (bus.mem_rvalid_i)
            state <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  logic gnt_now, rsp_now, if_rsp, ls_rsp;

  assign gnt_now = (state == S_ISSUE) & bus.mem_gnt_i;
  assign rsp_now = (state == S_WAIT) & bus.mem_rvalid_i;
  // A flush in the response cycle itself also kills the fetch data.
  assign if_rsp  = rsp_now & own_if & ~cancelled & ~bus.flush_i;
  assign ls_rsp  = rsp_now & ~own_if;

  assign bus.if_gnt_o    = gnt_now & own_if;
  assign bus.ls_gnt_o    = gnt_now & ~own_if;
  assign bus.if_rvalid_o = if_rsp;
  assign bus.ls_rvalid_o = ls_rsp;
  assign bus.if_rdata_o  = if_rsp ? bus.mem_rdata_i : '0;
  assign bus.ls_rdata_o  = ls_rsp ? bus.mem_rdata_i : '0;

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_adr_o   = cmd_q.adr;
  assign bus.mem_we_o    = cmd_q.we;
  assign bus.mem_wdata_o = cmd_q.wdata;
  assign bus.mem_size_o  = cmd_q.size;

`ifdef MEM_ARB_ERR_EN
  assign bus.if_err_o = if_rsp & bus.mem_err_i;
  assign bus.ls_err_o = ls_rsp & bus.mem_err_i;
`endif
endmodule

// File: tb/tb_mem_port_arb.sv
// Directed + randomized bench for mem_port_arb against a transaction-level reference model.
module tb_mem_port_arb;
  localparam int XLEN = 32;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arb_if #(.XLEN(XLEN)) bus ();
  mem_port_arb #(.XLEN(XLEN), .STARVE_MAX(SMAX)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  // Reference model: the single transaction in flight and the IF wait count.
  typedef struct packed {
    bit              is_if;
    logic [XLEN-1:0] adr;
    bit              we;
    logic [XLEN-1:0] wdata;
    logic [2:0]      size;
  } txn_t;

  txn_t cur;
  bit   busy, granted, cancelled;
  int   starve;
  int   total = 0;
  int   bad = 0;
  bit   o_if_gnt, o_ls_gnt, o_if_rv, o_ls_rv;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cur = '0; busy = 0; granted = 0; cancelled = 0; starve = 0;
  endtask

  task automatic model_update();
    bit fl;
    fl = bus.flush_i;
    if (!busy) begin
      bit elig_if, take_if;
      elig_if = bus.if_req_i && !fl;
      if (bus.ls_req_i || elig_if) begin
        take_if = elig_if && (!bus.ls_req_i || starve == SMAX);
        busy = 1; granted = 0; cancelled = 0;
        if (take_if) begin
          cur = '{1'b1, bus.if_adr_i, 1'b0, '0, 3'b010};
          starve = 0;
        end else begin
          cur = '{1'b0, bus.ls_adr_i, bus.ls_we_i, bus.ls_wdata_i, bus.ls_size_i};
          if (bus.if_req_i) starve = (starve + 1 > SMAX) ? SMAX : starve + 1;
        end
      end
    end else if (!granted) begin
      if (bus.mem_gnt_i) begin
        granted = 1;
        cancelled = cur.is_if && fl;
      end else if (cur.is_if && fl) begin
        busy = 0;
      end
    end else begin
      if (cur.is_if && fl) cancelled = 1;
      if (bus.mem_rvalid_i) busy = 0;
    end
  endtask

  // Compare every output with the model at the falling edge.
  task automatic sample();
    bit e_req, e_ifg, e_lsg, e_ifv, e_lsv;
    @(negedge clk);
    e_req = busy && !granted;
    e_ifg = e_req && cur.is_if && bus.mem_gnt_i;
    e_lsg = e_req && !cur.is_if && bus.mem_gnt_i;
    e_ifv = busy && granted && cur.is_if && bus.mem_rvalid_i && !cancelled && !bus.flush_i;
    e_lsv = busy && granted && !cur.is_if && bus.mem_rvalid_i;
    chk("mem_req", bus.mem_req_o, e_req);
    chk("mem_adr", bus.mem_adr_o, cur.adr);
    chk("mem_we", bus.mem_we_o, cur.we);
    chk("mem_wdata", bus.mem_wdata_o, cur.wdata);
    chk("mem_size", bus.mem_size_o, cur.size);
    chk("if_gnt", bus.if_gnt_o, e_ifg);
    chk("ls_gnt", bus.ls_gnt_o, e_lsg);
    chk("if_rvalid", bus.if_rvalid_o, e_ifv);
    chk("ls_rvalid", bus.ls_rvalid_o, e_lsv);
    chk("if_rdata", bus.if_rdata_o, e_ifv ? bus.mem_rdata_i : '0);
    chk("ls_rdata", bus.ls_rdata_o, e_lsv ? bus.mem_rdata_i : '0);
`ifdef MEM_ARB_ERR_EN
    chk("if_err", bus.if_err_o, e_ifv && bus.mem_err_i);
    chk("ls_err", bus.ls_err_o, e_lsv && bus.mem_err_i);
`endif
    o_if_gnt = bus.if_gnt_o; o_ls_gnt = bus.ls_gnt_o;
    o_if_rv = bus.if_rvalid_o; o_ls_rv = bus.ls_rvalid_o;
  endtask

  task automatic advance();
    if (!reset_n) model_reset(); else model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  // Ideal memory: grant immediately, respond the cycle after the grant.
  task automatic auto_mem();
    bus.mem_gnt_i    = busy && !granted;
    bus.mem_rvalid_i = busy && granted;
    bus.mem_rdata_i  = $urandom;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0;
    model_reset();
    cyc();
    reset_n = 1'b1;
  endtask

  bit exp_order [10];
  bit pflush;
  int n;
  bit seen;

  initial begin
    bus.flush_i = 0;
    bus.if_req_i = 0; bus.if_adr_i = '0;
    bus.ls_req_i = 0; bus.ls_adr_i = '0; bus.ls_we_i = 0; bus.ls_wdata_i = '0; bus.ls_size_i = '0;
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = '0;
`ifdef MEM_ARB_ERR_EN
    bus.mem_err_i = 0;
`endif
    model_reset();
    #1;

    // Reset state
    sample();
    chk("rst_mem_req", bus.mem_req_o, 0);
    chk("rst_mem_adr", bus.mem_adr_o, 0);
    advance();
    reset_n = 1'b1;
    cyc();

    // IF only: gnt at cycle 1, rvalid at cycle 3
    bus.if_req_i = 1; bus.if_adr_i = 32'h100;
    cyc();
    bus.mem_gnt_i = 1;
    sample();
    chk("if_only_gnt", bus.if_gnt_o, 1);
    chk("if_only_size", bus.mem_size_o, 3'b010);
    chk("if_only_adr", bus.mem_adr_o, 32'h100);
    advance();
    bus.if_req_i = 0; bus.mem_gnt_i = 0;
    cyc();
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hDEADBEEF;
    sample();
    chk("if_only_rvalid", bus.if_rvalid_o, 1);
    chk("if_only_rdata", bus.if_rdata_o, 32'hDEADBEEF);
    advance();
    bus.mem_rvalid_i = 0;
    cyc();

    // LS store held stable through ISSUE
    bus.ls_req_i = 1; bus.ls_adr_i = 32'h2004; bus.ls_we_i = 1;
    bus.ls_wdata_i = 32'h12345678; bus.ls_size_i = 3'b010;
    cyc();
    sample();
    chk("st_we", bus.mem_we_o, 1);
    chk("st_adr", bus.mem_adr_o, 32'h2004);
    chk("st_wdata", bus.mem_wdata_o, 32'h12345678);
    advance();
    bus.mem_gnt_i = 1;
    sample();
    chk("st_gnt", bus.ls_gnt_o, 1);
    advance();
    bus.ls_req_i = 0; bus.ls_we_i = 0; bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1;
    sample();
    chk("st_ack", bus.ls_rvalid_o, 1);
    advance();
    bus.mem_rvalid_i = 0;

    // Flush during IF ISSUE; pending LS served next
    bus.if_req_i = 1; bus.if_adr_i = 32'h200;
    cyc();
    bus.ls_req_i = 1; bus.ls_adr_i = 32'h3000; bus.ls_size_i = 3'b001;
    cyc();
    bus.flush_i = 1;
    sample();
    chk("fl_iss_nognt", bus.if_gnt_o, 0);
    advance();
    bus.flush_i = 0; bus.if_req_i = 0;
    sample();
    chk("fl_iss_reqdrop", bus.mem_req_o, 0);
    advance();
    bus.mem_gnt_i = 1;
    sample();
    chk("fl_iss_ls_adr", bus.mem_adr_o, 32'h3000);
    chk("fl_iss_ls_gnt", bus.ls_gnt_o, 1);
    advance();
    bus.ls_req_i = 0; bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1;
    cyc();
    bus.mem_rvalid_i = 0;

    // Flush during IF WAIT; response swallowed
    bus.if_req_i = 1; bus.if_adr_i = 32'h300;
    cyc();
    bus.mem_gnt_i = 1;
    cyc();
    bus.if_req_i = 0; bus.mem_gnt_i = 0; bus.flush_i = 1;
    cyc();
    bus.flush_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hCAFE0001;
    sample();
    chk("fl_wait_norv", bus.if_rvalid_o, 0);
    advance();
    bus.mem_rvalid_i = 0;
    bus.if_req_i = 1; bus.if_adr_i = 32'h304;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      auto_mem();
      sample();
      if (o_if_rv) seen = 1;
      advance();
      if (o_if_gnt) bus.if_req_i = 0;
    end
    chk("fl_wait_refetch", seen, 1);
    bus.if_req_i = 0; bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0;

    // Starvation: both held continuously
    do_reset();
    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    bus.if_req_i = 1; bus.if_adr_i = 32'h400;
    bus.ls_req_i = 1; bus.ls_adr_i = 32'h5000; bus.ls_we_i = 0; bus.ls_size_i = 3'b010;
    n = 0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      auto_mem();
      sample();
      if (o_if_gnt || o_ls_gnt) begin
        chk($sformatf("order%0d_is_if", n), o_if_gnt, exp_order[n]);
        n++;
      end
      advance();
      if (o_ls_gnt) bus.ls_adr_i = bus.ls_adr_i + 4;
      if (o_if_gnt) bus.if_adr_i = bus.if_adr_i + 4;
    end
    chk("order_count", n, 10);
    bus.if_req_i = 0; bus.ls_req_i = 0;
    for (int c = 0; c < 4; c++) begin auto_mem(); cyc(); end

`ifdef MEM_ARB_ERR_EN
    // Error routed to LS owner
    bus.ls_req_i = 1; bus.ls_adr_i = 32'h6000; bus.ls_we_i = 0;
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0;
    cyc();
    bus.mem_gnt_i = 1;
    cyc();
    bus.ls_req_i = 0; bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; bus.mem_err_i = 1;
    sample();
    chk("err_ls", bus.ls_err_o, 1);
    chk("err_ls_rv", bus.ls_rvalid_o, 1);
    chk("err_if_quiet", bus.if_err_o, 0);
    advance();
    bus.mem_rvalid_i = 0; bus.mem_err_i = 0;
`endif

    // Reset in the middle of a transaction
    bus.if_req_i = 1; bus.if_adr_i = 32'h700;
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0;
    cyc();
    bus.mem_gnt_i = 1;
    cyc();
    bus.if_req_i = 0; bus.mem_gnt_i = 0;
    reset_n = 1'b0;
    model_reset();
    sample();
    chk("midrst_req", bus.mem_req_o, 0);
    chk("midrst_adr", bus.mem_adr_o, 0);
    advance();
    reset_n = 1'b1;
    bus.ls_req_i = 1; bus.ls_adr_i = 32'h7100;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      auto_mem();
      sample();
      if (o_ls_rv) seen = 1;
      advance();
      if (o_ls_gnt) bus.ls_req_i = 0;
    end
    chk("midrst_recover", seen, 1);
    bus.ls_req_i = 0; bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0;

    // Randomized traffic, requesters honour hold-until-grant
    pflush = 0;
    for (int c = 0; c < 600; c++) begin
      bit g;
      if (!bus.if_req_i || o_if_gnt || pflush) begin
        bus.if_req_i = ($urandom % 3) != 0;
        bus.if_adr_i = $urandom & ~32'h3;
      end
      if (!bus.ls_req_i || o_ls_gnt) begin
        bus.ls_req_i   = ($urandom % 3) != 0;
        bus.ls_adr_i   = $urandom;
        bus.ls_we_i    = $urandom % 2;
        bus.ls_wdata_i = $urandom;
        bus.ls_size_i  = 3'($urandom);
      end
      bus.flush_i = ($urandom % 10) == 0;
      if (busy && !granted) begin
        g = $urandom % 2;
        bus.mem_gnt_i = g;
        bus.mem_rvalid_i = !g && ($urandom % 8 == 0);
      end else if (busy) begin
        bus.mem_gnt_i = 0;
        bus.mem_rvalid_i = $urandom % 2;
      end else begin
        g = ($urandom % 4) == 0;
        bus.mem_gnt_i = g;
        bus.mem_rvalid_i = !g && ($urandom % 8 == 0);
      end
      bus.mem_rdata_i = $urandom;
`ifdef MEM_ARB_ERR_EN
      bus.mem_err_i = ($urandom % 4) == 0;
`endif
      pflush = bus.flush_i;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end
endmodule

// File: doc/mem_port_arb.md
Name: mem_port_arb

Overview:
- Arbitrates the single shared memory port between the instruction-fetch requester (IF) and the execute-stage load/store unit (LS).
- Sits between the fetch unit, the exe LSU memory interface and the memory bus.
- Sequences exactly one outstanding transaction at a time using a request/grant/response protocol.
- Gives LS priority, bounded by an anti-starvation counter for IF; supports a fetch flush on branch or exception.

Parameters:
- XLEN, 32, data/address width.
- STARVE_MAX, 4, number of consecutive LS grants while IF is waiting before IF is forced to win; range 1..15.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- flush_i  in  1  exe flush; cancels IF transaction not yet responded
- if_req_i  in  1  IF request; held stable until if_gnt_o
- if_adr_i  in  XLEN  IF address
- if_gnt_o  out  1  IF request accepted by memory (1-cycle pulse)
- if_rvalid_o  out  1  IF response valid (1-cycle pulse)
- if_rdata_o  out  XLEN  IF read data
- ls_req_i  in  1  LS request; held stable until ls_gnt_o
- ls_adr_i  in  XLEN  LS address
- ls_we_i  in  1  LS store
- ls_wdata_i  in  XLEN  LS store data
- ls_size_i  in  3  LS access size
- ls_gnt_o  out  1  LS accepted (pulse)
- ls_rvalid_o  out  1  LS response valid (pulse; store acknowledge included)
- ls_rdata_o  out  XLEN  LS load data
- mem_req_o  out  1  memory request
- mem_adr_o  out  XLEN  memory address
- mem_we_o  out  1  memory write enable
- mem_wdata_o  out  XLEN  memory write data
- mem_size_o  out  3  memory access size; IF uses 3'b010 (word)
- mem_gnt_i  in  1  memory accepts the request
- mem_rvalid_i  in  1  memory response; never in the same cycle as its gnt
- mem_rdata_i  in  XLEN  memory read data

Behaviour:
- Reset:
  - State is IDLE; owner is LS; starve_cnt is 0.
  - All outputs are 0; the mem_* fields are registered and reset to 0.
- IDLE:
  - If ls_req_i and if_req_i are both set, IF wins only when starve_cnt == STARVE_MAX; otherwise LS wins.
  - A single requester wins alone.
  - IF is not eligible when flush_i is high in that cycle.
  - The winner's fields are registered into the mem_* registers and the owner is recorded; go to ISSUE next cycle.
  - With no eligible request, stay in IDLE.
- ISSUE:
  - mem_req_o = 1 with the registered fields held stable.
  - On mem_gnt_i, pulse the owner's gnt_o in the same cycle (combinational), drop mem_req_o next cycle, and go to WAIT.
  - If owner is IF and flush_i=1 before gnt: do not assert if_gnt_o, deassert mem_req_o, return to IDLE.
  - If flush_i and mem_gnt_i arrive in the same cycle, the grant wins; the transaction is marked cancelled.
- WAIT:
  - On mem_rvalid_i, pulse the owner's rvalid_o and pass mem_rdata_i to the owner's rdata_o in the same cycle; go to IDLE.
  - Non-owner rdata_o is 0.
  - If owner is IF and the transaction is cancelled (flush_i seen in WAIT, or at gnt), suppress if_rvalid_o; the bus response is still consumed.
- Minimum latency: request at cycle 0 → mem_req_o at cycle 1 → gnt at cycle 1 → rvalid at cycle 2 → IDLE at cycle 3. Back-to-back throughput is one transaction per 3 cycles.
- starve_cnt:
  - +1, saturating at STARVE_MAX, when LS wins in IDLE while if_req_i=1.
  - Cleared when IF wins.
  - Unchanged otherwise.
- LS transactions are never cancelled by flush_i.
- A response arriving in IDLE or ISSUE is a protocol error and is ignored.
- Reset mid-transaction: returns to IDLE immediately; the memory side must also be reset.

Optional Feature:
- Macro: MEM_ARB_ERR_EN.
- With the macro:
  - Adds input mem_err_i (1 bit, qualified by mem_rvalid_i) and outputs if_err_o / ls_err_o (1 bit).
  - The error is routed to the owner as a pulse alongside rvalid, suppressed for a cancelled IF transaction; exe maps it to an access fault.
  - Reset value is 0.
- Without the macro: these ports do not exist and memory errors are not observable.

Test Plan:
- IF only: if_req_i=1, adr 0x100, gnt at cycle 1, rvalid at cycle 3 with rdata 0xDEADBEEF → if_gnt_o pulse at cycle 1, if_rvalid_o at cycle 3 with 0xDEADBEEF, mem_size_o=3'b010.
- Simultaneous requests, STARVE_MAX=4, both held continuously: grant order LS,LS,LS,LS,IF,LS…; starve_cnt returns to 0 after the IF grant.
- LS store: adr 0x2004, wdata 0x12345678, size 3'b010 → mem_we_o=1 with those values held through ISSUE; ls_rvalid_o pulses on the ack.
- flush_i during IF ISSUE with mem_gnt_i held low for 2 cycles → no if_gnt_o, mem_req_o drops the next cycle, pending LS is served next.
- flush_i during IF WAIT, then rvalid → if_rvalid_o stays 0, FSM returns to IDLE; a new IF request proceeds normally.
- With MEM_ARB_ERR_EN: LS load with mem_err_i=1 on rvalid → ls_err_o=1 and ls_rvalid_o=1 in the same cycle; if_err_o stays 0.
